// File: rtl/toggle_seq_ctrl.sv
// toggle_seq_ctrl: steps an external T flip-flop bank as a modulo counter.
// Optional Gray-code stepping is enabled by defining TOGGLE_SEQ_GRAY_EN.
module toggle_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             one_shot,
`ifdef TOGGLE_SEQ_GRAY_EN
  input  logic             gray,
`endif
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q_vec,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             range_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic             r_err;
  logic             w_run;
  logic [WIDTH-1:0] w_tvec;
  logic             w_wrap;
  logic             w_oor;

`ifdef TOGGLE_SEQ_GRAY_EN
  localparam logic [WIDTH-1:0] C_MSB =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_low;
  logic [WIDTH-1:0] w_edge;
  logic             w_par;

  assign w_low  = q_vec & (~q_vec + WIDTH'(1));
  assign w_par  = ^q_vec;
  assign w_edge = dir ? '0 : C_MSB;
`endif

  assign w_run = (r_state == S_RUN);

  // Toggle vector: the step the bank takes at the next edge.
  // Gated by rst so the bank holds while reset is applied.
  always_comb begin
    w_tvec = '0;
    w_wrap = 1'b0;
    w_oor  = 1'b0;
    if (w_run && !rst) begin
`ifdef TOGGLE_SEQ_GRAY_EN
      if (gray) begin
        if (dir == w_par) begin
          w_tvec = WIDTH'(1);
        end else if (q_vec == w_edge) begin
          w_tvec = C_MSB;
          w_wrap = 1'b1;
        end else begin
          w_tvec = w_low << 1;
        end
      end else
`endif
      begin
        if (q_vec > limit) begin
          w_tvec = q_vec;
          w_oor  = 1'b1;
        end else if (!dir) begin
          if (q_vec == limit) begin
            w_tvec = q_vec;
            w_wrap = 1'b1;
          end else begin
            w_tvec = q_vec ^ (q_vec + WIDTH'(1));
          end
        end else begin
          if (q_vec == '0) begin
            w_tvec = limit;
            w_wrap = 1'b1;
          end else begin
            w_tvec = q_vec ^ (q_vec - WIDTH'(1));
          end
        end
      end
    end
  end

  // Control state and sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state <= S_RUN;
            r_err   <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_oor) r_err <= 1'b1;
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_wrap && one_shot) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign t_vec     = w_tvec;
  assign wrap      = w_wrap;
  assign busy      = w_run;
  assign done      = (r_state == S_DONE);
  assign range_err = r_err | w_oor;

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// tb_toggle_seq_ctrl: bank model plus arithmetic reference model.
// Gray cases are exercised when TOGGLE_SEQ_GRAY_EN is defined.
module tb_toggle_seq_ctrl;
  localparam int W = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst, start, stop, dir, one_shot;
  logic [W-1:0] limit, q_vec, t_vec;
  logic busy, wrap, done, range_err;
  logic gray;
  logic ld;
  logic [W-1:0] ld_val;

  int n_chk  = 0;
  int n_pass = 0;
  int m_st   = M_IDLE;
  bit m_err  = 1'b0;
  bit m_ok   = 1'b0;

  toggle_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .dir(dir),
    .one_shot(one_shot),
`ifdef TOGGLE_SEQ_GRAY_EN
    .gray(gray),
`endif
    .limit(limit),
    .q_vec(q_vec),
    .t_vec(t_vec),
    .busy(busy),
    .wrap(wrap),
    .done(done),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  // The external T flip-flop bank, with a preset path.
  always @(posedge clk)
    q_vec <= ld ? ld_val : (q_vec ^ t_vec);

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic int g2b(int g);
    int b = 0;
    for (int i = W - 1; i >= 0; i--)
      b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
    return b;
  endfunction

  // Reference: what the bank must become, and the flags.
  task automatic model();
    int nq = 0;
    int q = int'(q_vec);
    int l = int'(limit);
    bit oor = 0;
    bit wr = 0;
    logic [W-1:0] et = '0;
    bit g_on = 0;
`ifdef TOGGLE_SEQ_GRAY_EN
    g_on = gray;
`endif
    if (m_st == M_RUN && !rst) begin
      if (g_on) begin
        int b = g2b(q);
        int nb = dir ? (b + (1 << W) - 1) % (1 << W)
                     : (b + 1) % (1 << W);
        wr = dir ? (b == 0) : (b == (1 << W) - 1);
        nq = nb ^ (nb >> 1);
      end else if (q > l) begin
        nq = 0;
        oor = 1;
      end else if (!dir) begin
        wr = (q == l);
        nq = wr ? 0 : q + 1;
      end else begin
        wr = (q == 0);
        nq = wr ? l : q - 1;
      end
      et = q_vec ^ W'(nq);
    end
    if (m_ok) begin
      chk("t_vec", t_vec, et);
      chk("wrap", wrap, wr);
      chk("busy", busy, m_st == M_RUN);
      chk("done", done, m_st == M_DONE);
      chk("range_err", range_err, m_err | oor);
    end
    if (rst) begin
      m_st = M_IDLE;
      m_err = 0;
      m_ok = 1;
    end else if (m_st == M_IDLE) begin
      if (start && !stop) begin
        m_st = M_RUN;
        m_err = 0;
      end
    end else if (m_st == M_RUN) begin
      if (oor) m_err = 1;
      if (stop) m_st = M_IDLE;
      else if (wr && one_shot) m_st = M_DONE;
    end else begin
      m_st = M_IDLE;
    end
  endtask

  task automatic step(bit s, bit p, bit d, bit os,
                      logic [W-1:0] lim, bit r = 0,
                      bit g = 0, bit l = 0,
                      logic [W-1:0] lv = '0);
    @(negedge clk);
    rst = r; start = s; stop = p; dir = d;
    one_shot = os; limit = lim; gray = g;
    ld = l; ld_val = lv;
    #1;
    model();
  endtask

  logic [W-1:0] gseq [16] = '{4'd0, 4'd1, 4'd3, 4'd2,
    4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd13, 4'd15, 4'd14,
    4'd10, 4'd11, 4'd9, 4'd8};

  initial begin
    rst = 1; start = 0; stop = 0; dir = 0; one_shot = 0;
    limit = 9; gray = 0; ld = 1; ld_val = '0;
    step(0, 0, 0, 0, 9, 1, 0, 1, 0);
    step(0, 0, 0, 0, 9, 1, 0, 1, 0);
    step(0, 0, 0, 0, 9, 0, 0, 1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", range_err, 0);
    chk("rst_t", t_vec, 0);

    // Free-running up count, limit 9
    step(1, 0, 0, 0, 9);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 9);
      chk("t1_q", q_vec, i % 10);
      chk("t1_wrap", wrap, i == 9);
      chk("t1_busy", busy, 1);
      if (i == 9) chk("t1_t9", t_vec, 4'b1001);
    end
    step(0, 1, 0, 0, 9);

    // One-shot down count from 2, limit 5
    step(0, 0, 1, 1, 5, 0, 0, 1, 4'd2);
    step(1, 0, 1, 1, 5);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 5);
      chk("t2_q", q_vec, 2 - i);
    end
    chk("t2_t0", t_vec, 4'b0101);
    chk("t2_wrap", wrap, 1);
    step(1, 0, 1, 1, 5);
    chk("t2_done", done, 1);
    chk("t2_q5", q_vec, 5);
    chk("t2_dt", t_vec, 0);
    step(0, 0, 1, 1, 5);
    chk("t2_done0", done, 0);
    chk("t2_busy0", busy, 0);

    // Out-of-range preset, sticky error
    step(0, 0, 0, 0, 9, 0, 0, 1, 4'd12);
    step(1, 0, 0, 0, 9);
    step(0, 0, 0, 0, 9);
    chk("t3_t", t_vec, 4'b1100);
    chk("t3_err", range_err, 1);
    step(0, 1, 0, 0, 9);
    chk("t3_err_run", range_err, 1);
    step(0, 0, 0, 0, 9);
    chk("t3_err_idle", range_err, 1);
    step(1, 0, 0, 0, 9);
    step(0, 0, 0, 0, 9);
    chk("t3_err_clr", range_err, 0);
    step(0, 1, 0, 0, 9);

    // Stop with start in RUN at q=3
    step(0, 0, 0, 0, 9, 0, 0, 1, 4'd3);
    step(1, 0, 0, 0, 9);
    step(1, 1, 0, 0, 9);
    chk("t4_t", t_vec, 4'b0111);
    step(0, 0, 0, 0, 9);
    chk("t4_t0", t_vec, 0);
    chk("t4_busy", busy, 0);
    chk("t4_q", q_vec, 4);

    // Reset mid-run at q=6
    step(0, 0, 0, 0, 9, 0, 0, 1, 4'd6);
    step(1, 0, 0, 0, 9);
    step(0, 0, 0, 0, 9, 1);
    chk("t5_t", t_vec, 0);
    step(0, 0, 0, 0, 9);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", range_err, 0);
    chk("t5_q", q_vec, 6);

`ifdef TOGGLE_SEQ_GRAY_EN
    // Gray up-count over all states
    step(0, 0, 0, 0, 9, 0, 1, 1, 4'd0);
    step(1, 0, 0, 0, 9, 0, 1);
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 0, 0, 9, 0, 1);
      chk("t6_q", q_vec, gseq[i % 16]);
      chk("t6_pop", $countones(t_vec), 1);
      chk("t6_wrap", wrap, i == 15);
    end
    step(0, 1, 0, 0, 9, 0, 1);
`endif

    // Randomized traffic
    begin
      logic [W-1:0] lim = 4'd9;
      bit g = 0;
      for (int i = 0; i < 3000; i++) begin
        bit s = ($urandom_range(0, 99) < 30);
        bit p = ($urandom_range(0, 99) < 4);
        bit r = ($urandom_range(0, 199) == 0);
        bit os = ($urandom_range(0, 99) < 30);
        bit d = ($urandom_range(0, 99) < 40);
        bit l = (m_st == M_IDLE) &&
                ($urandom_range(0, 99) < 25);
        logic [W-1:0] lv = W'($urandom);
        if ($urandom_range(0, 99) < 3) lim = W'($urandom);
`ifdef TOGGLE_SEQ_GRAY_EN
        if ($urandom_range(0, 99) < 3) g = ~g;
`endif
        step(s, p, d, os, lim, r, g, l, lv);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
